// File: rtl/aes128_round_ctrl_if.sv
// Host-side handshake bundle for the AES-128 round controller.
// The master is the host or consumer side; the slave is the controller.
interface aes128_round_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid
  );
endinterface

// File: rtl/aes128_round_ctrl.sv
// aes128_round_ctrl: iterative sequencer for an AES-128 encryption datapath.
// It accepts one block and issues the load pulse, then launches the initial
// key add and rounds 1..NUM_ROUNDS. Each round occupies ROUND_LAT cycles.
// It then holds completion until the consumer takes the ciphertext.
module aes128_round_ctrl #(
  parameter int ROUND_LAT  = 1,
  parameter int NUM_ROUNDS = 10,
  parameter int CNT_W      = 16
) (
  input  logic               CLK,
  input  logic               RST,
  aes128_round_ctrl_if.slave hs,
  input  logic               abort,
  output logic               dp_load,
  output logic               dp_step,
  output logic [3:0]         round_idx,
  output logic               sub_en,
  output logic               mix_en,
  output logic               key_step,
  output logic               busy,
  output logic [CNT_W-1:0]   blk_count
);

  localparam int               SUB_W      = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(ROUND_LAT - 1);
  localparam logic [3:0]       LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t             state, state_nxt;
  logic [3:0]         round, round_nxt;
  logic [SUB_W-1:0]   sub, sub_nxt;
  logic [CNT_W-1:0]   cnt_nxt;

  // State, round, sub-cycle and completed-block registers.
  // Reset discards any in-flight block.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      round     <= '0;
      sub       <= '0;
      blk_count <= '0;
    end else begin
      state     <= state_nxt;
      round     <= round_nxt;
      sub       <= sub_nxt;
      blk_count <= cnt_nxt;
    end
  end

  // Next-state and output decode.
  // abort has priority over completion, and any unknown encoding falls back to IDLE.
  always_comb begin
    state_nxt    = state;
    round_nxt    = round;
    sub_nxt      = sub;
    cnt_nxt      = blk_count;
    hs.in_ready  = 1'b0;
    hs.out_valid = 1'b0;
    dp_load      = 1'b0;
    dp_step      = 1'b0;
    key_step     = 1'b0;
    sub_en       = 1'b0;
    mix_en       = 1'b0;
    busy         = 1'b0;
    round_idx    = round;

    case (state)
      S_IDLE: begin
        hs.in_ready = !RST;
        if (hs.in_valid && !RST) begin
          dp_load   = 1'b1;
          state_nxt = S_RUN;
          round_nxt = '0;
          sub_nxt   = '0;
        end
      end

      S_RUN: begin
        busy     = 1'b1;
        dp_step  = (sub == '0);
        key_step = (sub == '0) && (round != '0);
        sub_en   = (round != '0);
        mix_en   = (round != '0) && (round != LAST_ROUND);
        if (abort) begin
          state_nxt = S_IDLE;
          round_nxt = '0;
          sub_nxt   = '0;
        end else if (sub == SUB_LAST) begin
          sub_nxt = '0;
          if (round < LAST_ROUND) begin
            round_nxt = round + 4'd1;
          end else begin
            state_nxt = S_DONE;
          end
        end else begin
          sub_nxt = sub + SUB_W'(1);
        end
      end

      S_DONE: begin
        busy         = 1'b1;
        hs.out_valid = 1'b1;
        if (abort) begin
          state_nxt = S_IDLE;
          round_nxt = '0;
          sub_nxt   = '0;
        end else if (hs.out_ready) begin
          state_nxt = S_IDLE;
          round_nxt = '0;
          sub_nxt   = '0;
          cnt_nxt   = blk_count + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
        round_nxt = '0;
        sub_nxt   = '0;
      end
    endcase
  end

endmodule
